edp_muldiv: RTL

EDP_MULDIV -- requirements
Module: edp_muldiv

---
 rtl/edp_muldiv.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/edp_muldiv.sv
// Iterative multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle over a WIDTH-bit word.
module edp_muldiv #(
  parameter int WIDTH = 36,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             eboxClk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [0:1]       op,
  input  logic [0:WIDTH-1] opA,
  input  logic [0:WIDTH-1] opB,
  input  logic [0:WIDTH-1] opC,
  output logic             busy,
  output logic             done,
  output logic             divCheck,
  output logic [0:WIDTH-1] resHi,
  output logic [0:WIDTH-1] resLo
);

  localparam int W = WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [W-1:0]     w_c;
  logic             w_isDiv;
  logic             w_sA;
  logic             w_sB;
  logic [W-1:0]     w_magA;
  logic [W-1:0]     w_magB;
  logic [2*W-1:0]   w_dvd;
  logic [2*W-1:0]   w_dvdMag;
  logic             w_dc;

  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic [W-1:0]     r_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div;
  logic             r_dc;
  logic             r_negP;
  logic             r_negQ;
  logic             r_negR;
  logic [W-1:0]     r_resHi;
  logic [W-1:0]     r_resLo;
  logic             r_divCheck;

  logic [W:0]       w_mulSum;
  logic [W:0]       w_t;
  logic             w_ge;
  logic [W-1:0]     w_sub;
  logic [2*W-1:0]   w_prod;
  logic [2*W-1:0]   w_prodN;
  logic [W-1:0]     w_fixHi;
  logic [W-1:0]     w_fixLo;

  assign w_a      = opA;
  assign w_b      = opB;
  assign w_c      = opC;
  assign w_isDiv  = op[0];
  assign w_sA     = op[1] & w_a[W-1];
  assign w_sB     = op[1] & w_b[W-1];
  assign w_magA   = w_sA ? -w_a : w_a;
  assign w_magB   = w_sB ? -w_b : w_b;
  assign w_dvd    = {w_a, w_c};
  assign w_dvdMag = w_sA ? -w_dvd : w_dvd;

  // Quotient must fit the word (and be representable when signed)
  always_comb begin
    w_dc = 1'b0;
    if (w_isDiv) begin
      if (op[1])
        w_dc = (w_magB == '0) ||
               ((w_dvdMag >> (W - 1)) >= {{W{1'b0}}, w_magB});
      else
        w_dc = (w_a >= w_b);
    end
  end

  assign w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
  assign w_t      = {r_hi, r_lo[W-1]};
  assign w_ge     = (w_t >= {1'b0, r_d});
  assign w_sub    = w_t[W-1:0] - r_d;

  assign w_prod  = {r_hi, r_lo};
  assign w_prodN = -w_prod;

  always_comb begin
    w_fixHi = r_hi;
    w_fixLo = r_lo;
    if (r_div) begin
      if (r_negR) w_fixHi = -r_hi;
      if (r_negQ) w_fixLo = -r_lo;
    end else if (r_negP) begin
      w_fixHi = w_prodN[2*W-1:W];
      w_fixLo = w_prodN[W-1:0];
    end
  end

  always_ff @(posedge eboxClk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Divide-check skips the iteration but still passes through FIX
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = (w_isDiv && w_dc) ? FIX : RUN;
      RUN: begin
        if (abort)                      w_next = IDLE;
        else if (r_cnt == CNT_W'(1))    w_next = FIX;
      end
      FIX:  w_next = abort ? IDLE : DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge eboxClk) begin
    if (reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_div      <= 1'b0;
      r_dc       <= 1'b0;
      r_negP     <= 1'b0;
      r_negQ     <= 1'b0;
      r_negR     <= 1'b0;
      r_resHi    <= '0;
      r_resLo    <= '0;
      r_divCheck <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt <= CNT_W'(W);
            r_div <= w_isDiv;
            if (w_isDiv) begin
              r_dc   <= w_dc;
              r_hi   <= w_dc ? w_a : w_dvdMag[2*W-1:W];
              r_lo   <= w_dc ? w_c : w_dvdMag[W-1:0];
              r_d    <= w_magB;
              r_negP <= 1'b0;
              r_negQ <= ~w_dc & (w_sA ^ w_sB);
              r_negR <= ~w_dc & w_sA;
            end else begin
              r_dc   <= 1'b0;
              r_hi   <= '0;
              r_lo   <= w_magB;
              r_d    <= w_magA;
              r_negP <= w_sA ^ w_sB;
              r_negQ <= 1'b0;
              r_negR <= 1'b0;
            end
          end
        end
        RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_div) begin
            r_hi <= w_ge ? w_sub : w_t[W-1:0];
            r_lo <= {r_lo[W-2:0], w_ge};
          end else begin
            r_hi <= w_mulSum[W:1];
            r_lo <= {w_mulSum[0], r_lo[W-1:1]};
          end
        end
        FIX: begin
          if (!abort) begin
            r_resHi    <= w_fixHi;
            r_resLo    <= w_fixLo;
            r_divCheck <= r_dc;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign divCheck = r_divCheck;
  assign resHi    = r_resHi;
  assign resLo    = r_resLo;

endmodule
